cpu_fetch_unit: RTL and testbench
=================================

Name: cpu_fetch_unit

Overview:
Instruction fetch stage for the pipelined RV32I CPU. It is the producer end of the instruction/decode interface. It issues word reads to instruction memory and buffers returned words with their PCs in a small prefetch FIFO. It presents them to the decode stage over a valid/ready handshake and redirects on taken branch/jump from execute.

Parameters:
XLEN, 32, address/data width (only 32 supported)
RESET_PC, 32'h0000_0000, first fetch address after reset (word aligned)
FIFO_DEPTH, 4, prefetch entries; power of 2, >= 2

Ports:
clk  input  1  system clock, all logic rising-edge
rst  input  1  synchronous, active-high reset
fetch_en  input  1  1 = allowed to issue new memory requests
imem_req  output  1  request valid to instruction memory
imem_addr  output  XLEN  word address of request, [1:0]=00
imem_gnt  input  1  memory accepts request this cycle (req&gnt = issued)
imem_rvalid  input  1  read data valid; responses in issue order, >=1 cycle after issue
imem_rdata  input  XLEN  instruction word
redirect_en  input  1  taken branch/jump, flush and restart
redirect_pc  input  XLEN  restart address; bits [1:0] ignored (treated as 00)
if_valid  output  1  instruction available to decode
if_ready  input  1  decode accepts (handshake on valid&ready)
if_instr  output  XLEN  instruction word (opc = [6:0], funct3 = [14:12], funct7[5] = [30])
if_pc  output  XLEN  PC of if_instr
if_pc_plus4  output  XLEN  if_pc + 4, wraps modulo 2^32

Behaviour:
- Reset (rst=1 at edge): fetch_pc=RESET_PC, resp_pc=RESET_PC, FIFO empty, outstanding=0, discard=0. Outputs: imem_req=0, imem_addr=RESET_PC, if_valid=0, if_instr=0, if_pc=0, if_pc_plus4=4. Reset mid-transfer drops all in-flight state. Responses arriving after reset for pre-reset requests are the memory's responsibility (memory is reset together).
- Counters outstanding and discard are $clog2(FIFO_DEPTH)+1 bits wide. Invariant: FIFO count + outstanding <= FIFO_DEPTH.
- Request: imem_req = fetch_en & !redirect_en & (count + outstanding < FIFO_DEPTH); imem_addr = fetch_pc (combinational from register).
- On req&gnt: fetch_pc += 4 (wraps), outstanding++.
- While req & !gnt: addr held stable. Req may drop only through fetch_en=0, redirect, or reset.
- Response, imem_rvalid=1:
  - discard>0: word dropped, discard--.
  - Otherwise: push {resp_pc, imem_rdata}, resp_pc += 4, outstanding--.
  - Push never overflows, by the invariant.
  - Same-cycle issue and response both update outstanding (net 0).
- Output: if_valid = FIFO non-empty; if_instr/if_pc are the head entry, registered FIFO storage, no combinational path from imem_rdata. Pop on if_valid & if_ready.
- Latency: response at cycle N is visible at if_valid in cycle N+1; minimum fetch-to-decode latency is 2 cycles. Sustained throughput is 1 instr/cycle when gnt=1 and memory latency < FIFO_DEPTH.
- Push and pop in the same cycle on a full FIFO is legal only if the push slot exists by the invariant. Push and pop on a non-empty FIFO keep count constant.
- Redirect (redirect_en=1 at edge):
  - FIFO flushed, so if_valid=0 the next cycle. A pop in the same cycle still completes the handshake.
  - fetch_pc = resp_pc = {redirect_pc[XLEN-1:2],2'b00}.
  - imem_req=0 this cycle.
  - discard_next = discard + outstanding - imem_rvalid (a response this cycle belongs to the old stream); outstanding_next = 0.
  - First new-stream request is issued the cycle after the redirect.
  - Back-to-back redirects: the last one wins, and the discard accumulates.
- fetch_en=0: no new requests. Outstanding responses still complete and fill the FIFO; the FIFO still drains.
- PC wrap: 32'hFFFF_FFFC + 4 = 32'h0000_0000, with no flag.

Test Plan:
- Reset, fetch_en=1, gnt=1, 1-cycle memory returning addr-based words, if_ready=1 -> if_pc sequence 0,4,8,12, one per cycle after a 2-cycle fill; if_pc_plus4 = if_pc+4.
- if_ready=0 for 10 cycles, DEPTH=4 -> exactly 4 requests issued, then imem_req=0. After if_ready=1, order 0,4,8,12 is preserved and no instruction is lost.
- gnt held 0 for 3 cycles with req=1 -> imem_addr stable at 0x0 throughout; issue occurs on the gnt cycle only.
- 3-cycle memory latency, 2 outstanding, redirect_en with redirect_pc=0x103 -> the 2 old responses are dropped; the next if_pc is 0x100, then 0x104.
- Redirect in the same cycle as imem_rvalid and a pop -> the popped instr is counted as consumed, the response is dropped, and the FIFO is empty next cycle.
- RESET_PC=0xFFFF_FFF8 -> if_pc 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000; rst asserted mid-stream -> if_valid=0 and imem_req=0 the next cycle.

Source files
------------

// File: rtl/cpu_fetch_unit.sv
// Instruction fetch stage for the RV32I pipeline.
// Issues word reads to instruction memory, buffers the returned words with
// their PCs in a small prefetch FIFO and hands them to decode over a
// valid/ready handshake. A redirect from execute flushes the FIFO and marks
// every response still in flight as stale, so it is dropped when it returns.
module cpu_fetch_unit #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fetch_en,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_en,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pc_plus4
);

  localparam int            AW      = $clog2(FIFO_DEPTH);
  localparam int            CW      = AW + 1;
  localparam logic [CW:0]   DEPTH_W = (CW+1)'(FIFO_DEPTH);

  // Sequential PC step; wraps modulo 2^XLEN without any flag.
  function automatic logic [XLEN-1:0] pc_add4(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] resp_pc;
  logic [XLEN-1:0] instr_q [FIFO_DEPTH];
  logic [XLEN-1:0] pc_q    [FIFO_DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   discard;
  logic [XLEN-1:0] redirect_base;
  logic            room;
  logic            issue;
  logic            accept;
  logic            push;
  logic            pop;

  // ---- request stage: issue side towards instruction memory ----
  // Masking with ~3 keeps every bit of redirect_pc in use while forcing alignment.
  assign redirect_base = redirect_pc & ~XLEN'(3);
  // Reserving a FIFO slot per outstanding request guarantees pushes never overflow.
  assign room      = ({1'b0, count} + {1'b0, outstanding}) < DEPTH_W;
  assign imem_req  = !rst && fetch_en && !redirect_en && room;
  assign imem_addr = fetch_pc;
  assign issue     = imem_req && imem_gnt;

  // ---- response stage: stale responses are dropped, current ones are pushed ----
  assign accept = imem_rvalid && (discard == '0);
  assign push   = accept && !redirect_en;

  // ---- output stage: head of the registered FIFO, zeroed when empty ----
  assign if_valid    = (count != '0);
  assign pop         = if_valid && if_ready;
  assign if_instr    = if_valid ? instr_q[rd_ptr] : '0;
  assign if_pc       = if_valid ? pc_q[rd_ptr]    : '0;
  assign if_pc_plus4 = pc_add4(if_pc);

  // Control state: PCs, FIFO pointers and the in-flight bookkeeping counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
    end else if (redirect_en) begin
      fetch_pc    <= redirect_base;
      resp_pc     <= redirect_base;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      // A response arriving now belongs to the old stream, so it retires one stale slot.
      discard     <= discard + outstanding - CW'(imem_rvalid);
    end else begin
      if (issue) begin
        fetch_pc <= pc_add4(fetch_pc);
      end
      if (accept) begin
        resp_pc <= pc_add4(resp_pc);
      end
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count       <= count + CW'(push) - CW'(pop);
      outstanding <= outstanding + CW'(issue) - CW'(accept);
      if (imem_rvalid && (discard != '0)) begin
        discard <= discard - CW'(1);
      end
    end
  end

  // FIFO storage: data only, written on push and never reset.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_q[wr_ptr] <= imem_rdata;
      pc_q[wr_ptr]    <= resp_pc;
    end
  end

endmodule

// File: tb/tb_cpu_fetch_unit.sv
// Self-checking bench for cpu_fetch_unit: a table of per-cycle vectors for
// streaming and back-pressure, then hand-written sequences for grant stalls,
// redirects, PC wrap and mid-stream reset. A small in-order memory model with
// programmable latency answers requests with address-derived words.
module tb_cpu_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata  = '0;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;

  int n_tests   = 0;
  int n_fail    = 0;
  int lat       = 1;
  int edge_n    = 0;
  int issue_cnt = 0;

  logic [31:0] mq[$];
  int          md[$];

  cpu_fetch_unit #(
    .XLEN(32), .RESET_PC(32'h0000_0000), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr),
    .if_pc(if_pc), .if_pc_plus4(if_pc_plus4)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[31:16] ^ 16'hC0DE, a[15:0]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic check_req(input string tag, input logic req, input logic [31:0] addr);
    chk({tag, "_req"}, 32'(imem_req), 32'(req));
    if (req) chk({tag, "_addr"}, imem_addr, addr);
  endtask

  task automatic check_req_addr(input string tag, input logic req, input logic [31:0] addr);
    chk({tag, "_req"}, 32'(imem_req), 32'(req));
    chk({tag, "_addr"}, imem_addr, addr);
  endtask

  task automatic check_if(input string tag, input logic vld, input logic [31:0] pc);
    logic [31:0] epc;
    epc = vld ? pc : 32'h0;
    chk({tag, "_valid"}, 32'(if_valid), 32'(vld));
    chk({tag, "_pc"}, if_pc, epc);
    chk({tag, "_instr"}, if_instr, vld ? mem_word(pc) : 32'h0);
    chk({tag, "_pc4"}, if_pc_plus4, epc + 32'd4);
  endtask

  // In-order memory: capture issues just before the edge, return them lat edges later.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (rst) begin
        mq.delete();
        md.delete();
      end else if (imem_req && imem_gnt) begin
        mq.push_back(imem_addr);
        md.push_back(edge_n + lat);
        issue_cnt++;
      end
      @(posedge clk);
      #1;
      edge_n++;
      if (!rst && mq.size() > 0 && md[0] <= edge_n) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(mq.pop_front());
        void'(md.pop_front());
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
      end
    end
  end

  typedef struct {
    logic        fe;
    logic        gnt;
    logic        rdy;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc;
  } vec_t;

  vec_t tbl [26];

  initial begin
    int base_issue;
    int drained;
    int consumed;
    logic [31:0] exp_pc;

    // Streaming fill, then back-pressure, release and drain (1-cycle memory).
    for (int i = 0; i < 6; i++)
      tbl[i] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'(4*i), (i >= 2), 32'(4*(i-2))};
    for (int i = 6; i < 16; i++)
      tbl[i] = '{1'b1, 1'b1, 1'b0, (i < 8), (i < 8) ? 32'(24 + 4*(i-6)) : 32'd32, 1'b1, 32'd16};
    tbl[16] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'd32, 1'b1, 32'd16};
    for (int i = 17; i < 22; i++)
      tbl[i] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'(32 + 4*(i-17)), 1'b1, 32'(20 + 4*(i-17))};
    for (int i = 22; i < 25; i++)
      tbl[i] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'd52, 1'b1, 32'(40 + 4*(i-22))};
    tbl[25] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'd52, 1'b0, 32'd0};

    rst = 1'b1; fetch_en = 1'b1; imem_gnt = 1'b1; if_ready = 1'b0;
    redirect_en = 1'b0; redirect_pc = '0;
    repeat (2) @(negedge clk);
    #1;
    check_req_addr("reset", 1'b0, 32'h0);
    check_if("reset", 1'b0, 32'h0);

    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      rst = 1'b0;
      fetch_en = tbl[i].fe; imem_gnt = tbl[i].gnt; if_ready = tbl[i].rdy;
      #1;
      check_req_addr($sformatf("row%0d", i), tbl[i].req, tbl[i].addr);
      check_if($sformatf("row%0d", i), tbl[i].vld, tbl[i].pc);
    end

    // Grant withheld for three cycles: address stays put, one issue on the grant.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      fetch_en = 1'b1; imem_gnt = 1'b0; if_ready = 1'b1;
      #1;
      check_req_addr($sformatf("stall%0d", i), 1'b1, 32'h34);
    end
    @(negedge clk);
    imem_gnt = 1'b1; base_issue = issue_cnt;
    #1;
    check_req_addr("gnt", 1'b1, 32'h34);
    @(negedge clk);
    fetch_en = 1'b0;
    #1;
    check_req_addr("after_gnt", 1'b0, 32'h38);
    chk("issues_on_gnt", 32'(issue_cnt - base_issue), 32'd1);
    @(negedge clk); #1;
    check_if("stall_resp", 1'b1, 32'h34);
    @(negedge clk); #1;
    check_if("stall_empty", 1'b0, 32'h0);

    // Redirect with two 3-cycle responses in flight: both dropped.
    @(negedge clk);
    lat = 3; fetch_en = 1'b1;
    #1; check_req("rd0", 1'b1, 32'h38);
    @(negedge clk); #1; check_req("rd1", 1'b1, 32'h3C);
    @(negedge clk);
    redirect_en = 1'b1; redirect_pc = 32'h103;
    #1; check_req("rd2", 1'b0, 32'h0);
    @(negedge clk);
    redirect_en = 1'b0;
    #1; check_req("rd3", 1'b1, 32'h100); check_if("rd3", 1'b0, 32'h0);
    @(negedge clk); #1; check_req("rd4", 1'b1, 32'h104); check_if("rd4", 1'b0, 32'h0);
    @(negedge clk); #1; check_req("rd5", 1'b1, 32'h108); check_if("rd5", 1'b0, 32'h0);
    @(negedge clk); #1; check_if("rd6", 1'b0, 32'h0);
    @(negedge clk); #1; check_if("rd7", 1'b1, 32'h100);
    @(negedge clk);
    fetch_en = 1'b0;
    #1; check_if("rd8", 1'b1, 32'h104);
    exp_pc = 32'h108; drained = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      if (if_valid) begin
        chk($sformatf("drain%0d_pc", drained), if_pc, exp_pc);
        exp_pc = exp_pc + 32'd4;
        drained++;
      end
    end
    chk("drain_count", 32'(drained), 32'd2);
    chk("drain_empty", 32'(if_valid), 32'd0);

    // Redirect coinciding with a response and a pop.
    @(negedge clk);
    lat = 1; redirect_en = 1'b1; redirect_pc = 32'h200; fetch_en = 1'b1; if_ready = 1'b0;
    #1; check_req("rs0", 1'b0, 32'h0);
    @(negedge clk);
    redirect_en = 1'b0;
    #1; check_req("rs1", 1'b1, 32'h200); check_if("rs1", 1'b0, 32'h0);
    @(negedge clk); #1; check_req("rs2", 1'b1, 32'h204); check_if("rs2", 1'b0, 32'h0);
    @(negedge clk);
    redirect_en = 1'b1; redirect_pc = 32'h300; if_ready = 1'b1;
    #1;
    check_req("rs3", 1'b0, 32'h0);
    check_if("rs3", 1'b1, 32'h200);
    consumed = (if_valid && if_ready) ? 1 : 0;
    chk("rs3_consumed", 32'(consumed), 32'd1);
    @(negedge clk);
    redirect_en = 1'b0;
    #1; check_req("rs4", 1'b1, 32'h300); check_if("rs4", 1'b0, 32'h0);
    @(negedge clk); #1; check_req("rs5", 1'b1, 32'h304); check_if("rs5", 1'b0, 32'h0);
    @(negedge clk); #1; check_if("rs6", 1'b1, 32'h300);

    // Unaligned redirect near the top of the address space: PC wraps to zero.
    @(negedge clk);
    redirect_en = 1'b1; redirect_pc = 32'hFFFF_FFF9;
    #1; check_req("wr0", 1'b0, 32'h0);
    @(negedge clk);
    redirect_en = 1'b0;
    #1; check_req("wr1", 1'b1, 32'hFFFF_FFF8); check_if("wr1", 1'b0, 32'h0);
    @(negedge clk); #1; check_req("wr2", 1'b1, 32'hFFFF_FFFC); check_if("wr2", 1'b0, 32'h0);
    @(negedge clk); #1; check_req("wr3", 1'b1, 32'h0); check_if("wr3", 1'b1, 32'hFFFF_FFF8);
    @(negedge clk); #1; check_req("wr4", 1'b1, 32'h4); check_if("wr4", 1'b1, 32'hFFFF_FFFC);
    @(negedge clk); #1; check_if("wr5", 1'b1, 32'h0);

    // Reset in the middle of a running stream.
    @(negedge clk);
    rst = 1'b1;
    #1; check_req("mr0", 1'b0, 32'h0);
    @(negedge clk); #1;
    check_req_addr("mr1", 1'b0, 32'h0);
    check_if("mr1", 1'b0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1; check_req("mr2", 1'b1, 32'h0); check_if("mr2", 1'b0, 32'h0);
    @(negedge clk); #1; check_req("mr3", 1'b1, 32'h4); check_if("mr3", 1'b0, 32'h0);
    @(negedge clk); #1; check_if("mr4", 1'b1, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
